xadc_sampler: RTL and testbench
===============================

// Module: xadc_sampler
// PURPOSE
//  DRP read sequencer and conditioner that sits between the xadc_wiz_0 primitive and the arm controller.
//  Waits for end-of-conversion and issues a proper single-cycle DRP read (den pulse, not tied high).
//  Captures the 12-bit result and averages 2**AVG_LOG2 samples.
//  Applies hysteresis and presents a stable 8-bit xadc_x with a one-cycle update strobe.
// PARAMETERS
//  CHANNEL_ADDR  7'h1f  DRP address read on each EOC (VAUX15 status register)
//  AVG_LOG2      3      log2 of samples per average (8); legal 0..6
//  HYST          2      min |new-old| in LSBs of xadc_x required to update the output
//  TIMEOUT       255    max clk cycles waited for drdy_in after den_out
// PORTS
//  clk           in   1   10 MHz system clock; same clock as the XADC dclk_in
//  reset         in   1   asynchronous, active-high reset
//  eoc_in        in   1   XADC end-of-conversion pulse
//  drdy_in       in   1   XADC DRP data-ready pulse
//  do_in         in   16  XADC DRP read data; result is in [15:4]
//  den_out       out  1   DRP enable, one-cycle pulse per read
//  daddr_out     out  7   DRP address; constant CHANNEL_ADDR
//  xadc_x        out  8   filtered arm x-coordinate
//  xadc_x_valid  out  1   one-cycle pulse on the cycle xadc_x changes
//  rd_timeout    out  1   one-cycle pulse when a DRP read is abandoned
// BEHAVIOUR
//  Reset: state=IDLE, den_out=0, xadc_x=8'h00, xadc_x_valid=0, rd_timeout=0, acc=0, cnt=0, have_out=0.
//  daddr_out is held at CHANNEL_ADDR at all times, including during reset.
//  FSM IDLE/REQ/WAIT/FILT, all outputs registered:
//   IDLE: if eoc_in -> REQ.
//   REQ: den_out=1 for exactly this cycle -> WAIT; wait counter cleared.
//   WAIT: if drdy_in, then acc += do_in[15:4], cnt++ (synchronous to the drdy cycle).
//     Next state is FILT if cnt was 2**AVG_LOG2-1, else IDLE.
//   WAIT timeout: else if wait counter == TIMEOUT, pulse rd_timeout -> IDLE, with acc and cnt unchanged.
//   WAIT eoc_in is ignored (sample dropped, no queueing).
//   FILT: avg = acc >> AVG_LOG2 (12 bit); cand = avg[11:4].
//     Update condition: !have_out or |cand - xadc_x| >= HYST, evaluated as a 9-bit signed difference.
//     On update: xadc_x <= cand, xadc_x_valid pulses, have_out <= 1.
//     Always: acc <= 0, cnt <= 0 -> IDLE.
//  Latency: den_out is high 1 cycle after eoc_in.
//   xadc_x/xadc_x_valid appear 2 cycles after the final drdy_in of a block.
//  Widths: acc is 12+AVG_LOG2 bits and cannot overflow (max 4095*2**AVG_LOG2).
//   cnt is AVG_LOG2 bits and wraps naturally.
//   When AVG_LOG2=0, every sample goes to FILT.
//  drdy_in outside WAIT is ignored; eoc_in in REQ or FILT is ignored.
//  Reset mid-operation returns to IDLE immediately and discards the partial average.
//   The next first result updates unconditionally (have_out=0).
//  xadc_x_valid and rd_timeout never assert in the same cycle.
// STRUCTURE
//  Shared package xadc_pkg:
//   typedef enum logic [1:0] {IDLE,REQ,WAIT,FILT} xs_state_t
//   localparam XADC_RES_W=12, XADC_X_W=8
//  One sub-module: xadc_avg_hyst (accumulator + FILT compare/update), driven by a sample strobe.
//  FSM and timeout counter stay in the top level.
// TESTING
//  Bench models the DRP: drdy_in asserts 3 cycles after den_out unless suppressed.
//  1 Reset release, 8 EOCs with do_in=16'h8000 -> 8 den pulses, each 1 cycle;
//    xadc_x=8'h80, one valid pulse 2 cycles after the 8th drdy.
//  2 Then 8 samples of 16'h8100 -> avg 12'h810, cand 8'h81, diff 1 < HYST -> no valid, xadc_x stays 8'h80.
//    Then 8 samples of 16'h8300 -> xadc_x=8'h83 with valid.
//  3 Alternate do_in 16'h0000/16'hFFF0 over 8 samples -> avg 12'h7FF -> xadc_x=8'h7F with valid.
//  4 EOC with drdy suppressed -> rd_timeout pulses 256 cycles after den_out, state IDLE, cnt unchanged.
//    Next read still counts toward the same block.
//  5 eoc_in asserted during WAIT -> no extra den_out; exactly one sample accumulated per read.
//  6 Assert reset after 5 samples -> all outputs at reset values; first block after release updates
//    xadc_x even when cand equals the old value.
//  Assertions: den_out never high 2 consecutive cycles; daddr_out==CHANNEL_ADDR always;
//   valid implies xadc_x changed or first output.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and widths for the XADC DRP sampling path.
package xadc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILT = 2'd3
    } xs_state_t;

    localparam int XADC_RES_W = 12;
    localparam int XADC_X_W   = 8;

    // Magnitude of (a - b), computed as a 9-bit signed difference so that
    // no 8-bit operand pair can wrap.
    function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff9 = diff[8] ? (~diff + 9'd1) : diff;
    endfunction

endpackage

// File: rtl/xadc_avg_hyst.sv
// Block averager with hysteresis: accumulates one 12-bit sample per
// sample_stb and, on filt_stb, turns the block average into the 8-bit output.
module xadc_avg_hyst
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int HYST     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_stb,
    input  logic [XADC_RES_W-1:0] sample,
    input  logic                  filt_stb,
    output logic                  block_last,
    output logic [XADC_X_W-1:0]   xadc_x,
    output logic                  xadc_x_valid
);

    localparam int ACC_W = XADC_RES_W + AVG_LOG2;
    // A zero-width counter is not legal, so AVG_LOG2=0 keeps a dummy bit.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic                  have_out;
    logic [ACC_W-1:0]      acc_sh;
    logic [XADC_RES_W-1:0] avg;
    logic [XADC_X_W-1:0]   cand;
    logic                  do_update;

    // With one sample per block, every sample closes the block.
    assign block_last = (AVG_LOG2 == 0) ? 1'b1 : (cnt == CNT_LAST);

    // Block average, candidate output and the hysteresis decision.
    always_comb begin
        acc_sh    = acc >> AVG_LOG2;
        avg       = acc_sh[XADC_RES_W-1:0];
        cand      = avg[XADC_RES_W-1:XADC_RES_W-XADC_X_W];
        do_update = !have_out || (abs_diff9(cand, xadc_x) >= 9'(HYST));
    end

    // Accumulate samples; on filter, maybe update the output and start a new block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= '0;
            have_out     <= 1'b0;
            xadc_x       <= '0;
            xadc_x_valid <= 1'b0;
        end else begin
            xadc_x_valid <= 1'b0;
            if (filt_stb) begin
                acc <= '0;
                cnt <= '0;
                if (do_update) begin
                    xadc_x       <= cand;
                    xadc_x_valid <= 1'b1;
                    have_out     <= 1'b1;
                end
            end else if (sample_stb) begin
                acc <= acc + ACC_W'(sample);
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_sampler.sv
// DRP read sequencer for the XADC: one single-cycle den per end-of-conversion,
// bounded wait for drdy, then hand the 12-bit result to the averager.
// Handshake: den_out is a one-cycle request; the first drdy_in seen while in
// WAIT completes it; eoc_in outside IDLE and drdy_in outside WAIT are dropped.
module xadc_sampler
    import xadc_pkg::*;
#(
    parameter logic [6:0] CHANNEL_ADDR = 7'h1f,
    parameter int         AVG_LOG2     = 3,
    parameter int         HYST         = 2,
    parameter int         TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                eoc_in,
    input  logic                drdy_in,
    input  logic [15:0]         do_in,
    output logic                den_out,
    output logic [6:0]          daddr_out,
    output logic [XADC_X_W-1:0] xadc_x,
    output logic                xadc_x_valid,
    output logic                rd_timeout,
    output xs_state_t           state_dbg
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    xs_state_t         state;
    xs_state_t         next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              sample_stb;
    logic              filt_stb;
    logic              timeout_hit;
    logic              block_last;

    assign daddr_out = CHANNEL_ADDR;
    assign state_dbg = state;

    // Next-state and per-cycle strobes.
    always_comb begin
        next_state  = state;
        sample_stb  = 1'b0;
        filt_stb    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (eoc_in) next_state = REQ;
            end
            REQ: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (drdy_in) begin
                    sample_stb = 1'b1;
                    next_state = block_last ? FILT : IDLE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end
            FILT: begin
                filt_stb   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Wait counter: zero in the REQ cycle, so drdy is accepted up to TIMEOUT cycles after den.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               wait_cnt <= '0;
        else if (state == IDLE)                  wait_cnt <= '0;
        else if (state == REQ || state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    // Registered DRP enable and timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            den_out    <= 1'b0;
            rd_timeout <= 1'b0;
        end else begin
            den_out    <= (next_state == REQ);
            rd_timeout <= timeout_hit;
        end
    end

    xadc_avg_hyst #(
        .AVG_LOG2 (AVG_LOG2),
        .HYST     (HYST)
    ) u_avg_hyst (
        .clk          (clk),
        .reset        (reset),
        .sample_stb   (sample_stb),
        .sample       (do_in[15:4]),
        .filt_stb     (filt_stb),
        .block_last   (block_last),
        .xadc_x       (xadc_x),
        .xadc_x_valid (xadc_x_valid)
    );

endmodule

// File: tb/tb_xadc_sampler.sv
// Directed bench for xadc_sampler with a DRP model that answers 3 cycles after den.
module tb_xadc_sampler;
    import xadc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic [7:0]  xadc_x;
    logic        xadc_x_valid;
    logic        rd_timeout;
    xs_state_t   state_dbg;

    int total = 0;
    int bad   = 0;

    // Per-read observations (window index = cycles after the eoc window).
    int          r_den_cnt, r_den_w, r_valid_cnt, r_valid_w, r_to_cnt, r_to_w;
    logic [7:0]  r_valid_x;
    xs_state_t   r_to_state;

    // Monitor state.
    logic        den_prev;
    logic        seen_out;
    logic [7:0]  x_prev;

    // Clock / reset block.
    always #5 clk = ~clk;

    xadc_sampler dut (
        .clk          (clk),
        .reset        (reset),
        .eoc_in       (eoc_in),
        .drdy_in      (drdy_in),
        .do_in        (do_in),
        .den_out      (den_out),
        .daddr_out    (daddr_out),
        .xadc_x       (xadc_x),
        .xadc_x_valid (xadc_x_valid),
        .rd_timeout   (rd_timeout),
        .state_dbg    (state_dbg)
    );

    // Continuous protocol checks, sampled on the falling edge.
    always @(negedge clk) begin
        total++;
        if (daddr_out !== 7'h1f) begin
            bad++;
            $display("FAIL daddr: got %h want 1f", daddr_out);
        end
        if (den_out && den_prev) begin
            total++;
            bad++;
            $display("FAIL den_two_cycles: den_out high on consecutive cycles");
        end
        if (xadc_x_valid && rd_timeout) begin
            total++;
            bad++;
            $display("FAIL valid_and_timeout: both asserted together");
        end
        if (reset) begin
            seen_out = 1'b0;
        end else if (xadc_x_valid) begin
            total++;
            if (seen_out && xadc_x === x_prev) begin
                bad++;
                $display("FAIL valid_no_change: x=%h prev=%h", xadc_x, x_prev);
            end
            seen_out = 1'b1;
        end
        den_prev = den_out;
        x_prev   = xadc_x;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: one EOC and the DRP response, observing outputs each window.
    task automatic do_read(input logic [15:0] data, input bit drop, input bit eoc_mid, input bit stray_drdy);
        int n;
        n = drop ? 260 : 8;
        r_den_cnt = 0; r_den_w = -1; r_valid_cnt = 0; r_valid_w = -1;
        r_to_cnt = 0; r_to_w = -1; r_valid_x = 8'h00; r_to_state = FILT;
        eoc_in = 1'b1;
        for (int w = 1; w <= n; w++) begin
            step();
            if (den_out)      begin r_den_cnt++; r_den_w = w; end
            if (xadc_x_valid) begin r_valid_cnt++; r_valid_w = w; r_valid_x = xadc_x; end
            if (rd_timeout)   begin r_to_cnt++; r_to_w = w; r_to_state = state_dbg; end
            eoc_in  = eoc_mid && (w == 2);
            drdy_in = (!drop && w == 4) || (stray_drdy && w == 6);
            if (w == 4)                  do_in = data;
            else if (stray_drdy && w == 6) do_in = 16'hFFF0;
            else                         do_in = 16'h5A50;
        end
        eoc_in  = 1'b0;
        drdy_in = 1'b0;
    endtask

    // Driver: a full block of 8 reads alternating d0/d1.
    task automatic run_block(input logic [15:0] d0, input logic [15:0] d1, input bit eoc_mid,
                             input bit stray, output int early_valid, output int den_total);
        early_valid = 0;
        den_total   = 0;
        for (int i = 0; i < 8; i++) begin
            do_read((i % 2 == 0) ? d0 : d1, 1'b0, eoc_mid, stray);
            den_total += r_den_cnt;
            if (i < 7) early_valid += r_valid_cnt;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; eoc_in = 1'b0; drdy_in = 1'b0; do_in = 16'h0000;
        step(); step();
        total++; if (den_out !== 1'b0)      begin bad++; $display("FAIL reset_den: got %b want 0", den_out); end
        total++; if (xadc_x !== 8'h00)      begin bad++; $display("FAIL reset_x: got %h want 00", xadc_x); end
        total++; if (xadc_x_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", xadc_x_valid); end
        total++; if (rd_timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b want 0", rd_timeout); end
        total++; if (state_dbg !== IDLE)    begin bad++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_first_block();
        int ev, dt;
        run_block(16'h8000, 16'h8000, 1'b0, 1'b0, ev, dt);
        total++; if (dt != 8)          begin bad++; $display("FAIL first_den_count: got %0d want 8", dt); end
        total++; if (r_den_w != 1)     begin bad++; $display("FAIL first_den_latency: got %0d want 1", r_den_w); end
        total++; if (ev != 0)          begin bad++; $display("FAIL first_early_valid: got %0d want 0", ev); end
        total++; if (r_valid_cnt != 1) begin bad++; $display("FAIL first_valid_count: got %0d want 1", r_valid_cnt); end
        total++; if (r_valid_w != 6)   begin bad++; $display("FAIL first_valid_latency: got %0d want 6", r_valid_w); end
        total++; if (r_valid_x !== 8'h80) begin bad++; $display("FAIL first_x: got %h want 80", r_valid_x); end
    endtask

    task automatic test_hysteresis();
        int ev, dt;
        run_block(16'h8100, 16'h8100, 1'b0, 1'b0, ev, dt);
        total++; if (ev + r_valid_cnt != 0) begin bad++; $display("FAIL hyst_small_valid: got %0d want 0", ev + r_valid_cnt); end
        total++; if (xadc_x !== 8'h80)      begin bad++; $display("FAIL hyst_small_x: got %h want 80", xadc_x); end
        run_block(16'h8300, 16'h8300, 1'b0, 1'b0, ev, dt);
        total++; if (r_valid_cnt != 1 || ev != 0) begin bad++; $display("FAIL hyst_big_valid: got %0d/%0d want 1/0", r_valid_cnt, ev); end
        total++; if (r_valid_x !== 8'h83)   begin bad++; $display("FAIL hyst_big_x: got %h want 83", r_valid_x); end
    endtask

    task automatic test_alternate();
        int ev, dt;
        run_block(16'h0000, 16'hFFF0, 1'b0, 1'b0, ev, dt);
        total++; if (r_valid_cnt != 1 || ev != 0) begin bad++; $display("FAIL alt_valid: got %0d/%0d want 1/0", r_valid_cnt, ev); end
        total++; if (r_valid_x !== 8'h7F) begin bad++; $display("FAIL alt_x: got %h want 7f", r_valid_x); end
    endtask

    task automatic test_timeout();
        int ev;
        ev = 0;
        for (int i = 0; i < 3; i++) begin
            do_read(16'h4000, 1'b0, 1'b0, 1'b0);
            ev += r_valid_cnt;
        end
        do_read(16'h4000, 1'b1, 1'b0, 1'b0);
        total++; if (r_to_cnt != 1)      begin bad++; $display("FAIL to_count: got %0d want 1", r_to_cnt); end
        total++; if (r_to_w != 257)      begin bad++; $display("FAIL to_latency: got %0d want 257", r_to_w); end
        total++; if (r_to_state !== IDLE) begin bad++; $display("FAIL to_state: got %0d want IDLE", r_to_state); end
        total++; if (r_den_cnt != 1)     begin bad++; $display("FAIL to_den: got %0d want 1", r_den_cnt); end
        ev += r_valid_cnt;
        for (int i = 0; i < 5; i++) begin
            do_read(16'h4000, 1'b0, 1'b0, 1'b0);
            if (i < 4) ev += r_valid_cnt;
        end
        total++; if (ev != 0)            begin bad++; $display("FAIL to_early_valid: got %0d want 0", ev); end
        total++; if (r_valid_cnt != 1)   begin bad++; $display("FAIL to_block_valid: got %0d want 1", r_valid_cnt); end
        total++; if (r_valid_x !== 8'h40) begin bad++; $display("FAIL to_x: got %h want 40", r_valid_x); end
    endtask

    task automatic test_eoc_in_wait();
        int ev, dt;
        run_block(16'hC000, 16'hC000, 1'b1, 1'b1, ev, dt);
        total++; if (dt != 8)          begin bad++; $display("FAIL eocwait_den: got %0d want 8", dt); end
        total++; if (ev != 0)          begin bad++; $display("FAIL eocwait_early_valid: got %0d want 0", ev); end
        total++; if (r_valid_cnt != 1) begin bad++; $display("FAIL eocwait_valid: got %0d want 1", r_valid_cnt); end
        total++; if (r_valid_x !== 8'hC0) begin bad++; $display("FAIL eocwait_x: got %h want c0", r_valid_x); end
    endtask

    task automatic test_reset_mid();
        int ev, dt;
        for (int i = 0; i < 5; i++) do_read(16'h2000, 1'b0, 1'b0, 1'b0);
        eoc_in = 1'b1;
        step();
        eoc_in = 1'b0;
        step();
        reset = 1'b1;
        #1;
        total++; if (xadc_x !== 8'h00)   begin bad++; $display("FAIL rstmid_x: got %h want 00", xadc_x); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want IDLE", state_dbg); end
        total++; if (den_out !== 1'b0 || xadc_x_valid !== 1'b0 || rd_timeout !== 1'b0) begin
            bad++; $display("FAIL rstmid_pulses: den=%b valid=%b to=%b want 000", den_out, xadc_x_valid, rd_timeout);
        end
        step(); step();
        reset = 1'b0;
        step();
        run_block(16'h0000, 16'h0000, 1'b0, 1'b0, ev, dt);
        total++; if (ev != 0)          begin bad++; $display("FAIL rstmid_early_valid: got %0d want 0", ev); end
        total++; if (r_valid_cnt != 1) begin bad++; $display("FAIL rstmid_first_valid: got %0d want 1", r_valid_cnt); end
        total++; if (r_valid_w != 6)   begin bad++; $display("FAIL rstmid_latency: got %0d want 6", r_valid_w); end
        total++; if (r_valid_x !== 8'h00) begin bad++; $display("FAIL rstmid_x_after: got %h want 00", r_valid_x); end
    endtask

    initial begin
        den_prev = 1'b0; seen_out = 1'b0; x_prev = 8'h00;
        test_reset();
        test_first_block();
        test_hysteresis();
        test_alternate();
        test_timeout();
        test_eoc_in_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
